// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame parser:
//   state_t         - parser FSM states
//   ERR_*           - err_code values reported by the parser
//   DEFAULT_HEADER  - default frame start byte
//   sat_inc16()     - saturating 16-bit increment for the optional statistics
//                     counters (UART_FRAME_STATS_EN)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// ---------------------------------------------------------------------------
// uart_frame_buf
// Payload storage: DEPTH x 8 register file, one synchronous write port and
// one asynchronous (combinational) read port. Contents are not reset; the
// parser only reads entries it has written for the current frame.
//   i_clk    - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Parses byte-stream frames  HEADER, LEN, LEN payload bytes, CHK
// with CHK = (LEN + sum(payload)) mod 256, buffers the payload and replays it
// on a valid/ready output. Bad length, checksum mismatch and inter-byte
// timeout are reported as a one-cycle frame_err pulse plus a sticky err_code.
// Bytes arriving while the payload is being replayed are dropped (overrun).
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   byte_valid, byte_data - one-cycle input byte strobe and data
//   out_valid, out_ready  - payload output handshake
//   out_data, out_last    - payload byte, last-byte-of-frame flag
//   frame_err, err_code   - error pulse, last error (01 len, 10 chk, 11 tmo)
//   overrun               - pulse when an input byte is dropped
//   good_cnt, bad_cnt     - saturating frame counters, present only when the
//                           macro UART_FRAME_STATS_EN is defined
// ---------------------------------------------------------------------------
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 17360
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        overrun
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    logic [7:0]    r_len;
    logic [7:0]    r_sum;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [TW-1:0] r_idle_cnt;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic          r_out_last;
    logic          r_frame_err;
    logic [1:0]    r_err_code;
    logic          r_overrun;
`ifdef UART_FRAME_STATS_EN
    logic [15:0]   r_good_cnt;
    logic [15:0]   r_bad_cnt;
`endif

    logic          w_collecting;
    logic          w_tmo;
    logic          w_buf_we;
    logic [7:0]    w_next_idx;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;
    logic          w_next_last;

    assign w_collecting = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                          (r_state == ST_CHECK);
    // Timeout only fires on a cycle with no byte: a byte on the boundary
    // cycle still counts as activity.
    assign w_tmo        = w_collecting && !byte_valid && (r_idle_cnt == TMO_LAST);
    assign w_buf_we     = (r_state == ST_PAYLOAD) && byte_valid;

    // Index of the byte to present next: the current one while the output
    // register is empty, the following one when a handshake is completing.
    assign w_next_idx   = r_out_valid ? (8'(r_rd_ptr) + 8'd1) : 8'(r_rd_ptr);
    assign w_rd_addr    = w_next_idx[AW-1:0];
    assign w_next_last  = (w_next_idx == (r_len - 8'd1));

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk   (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (byte_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Inter-byte idle counter, live only while a frame is being collected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_collecting || byte_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= 8'd0;
            r_sum       <= 8'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_overrun   <= 1'b0;
`ifdef UART_FRAME_STATS_EN
            r_good_cnt  <= 16'd0;
            r_bad_cnt   <= 16'd0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (byte_valid && (byte_data == HEADER)) begin
                        r_state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (byte_valid) begin
                        if ((byte_data == 8'd0) || (byte_data > MAX_LEN_B)) begin
                            r_state     <= ST_IDLE;
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_LEN;
`ifdef UART_FRAME_STATS_EN
                            r_bad_cnt   <= sat_inc16(r_bad_cnt);
`endif
                        end else begin
                            r_len    <= byte_data;
                            r_sum    <= byte_data;
                            r_wr_ptr <= '0;
                            r_state  <= ST_PAYLOAD;
                        end
                    end else if (w_tmo) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TMO;
`ifdef UART_FRAME_STATS_EN
                        r_bad_cnt   <= sat_inc16(r_bad_cnt);
`endif
                    end
                end

                ST_PAYLOAD: begin
                    if (byte_valid) begin
                        // The buffer write itself happens through w_buf_we.
                        r_sum    <= r_sum + byte_data;
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if ((8'(r_wr_ptr) + 8'd1) == r_len) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_tmo) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TMO;
`ifdef UART_FRAME_STATS_EN
                        r_bad_cnt   <= sat_inc16(r_bad_cnt);
`endif
                    end
                end

                ST_CHECK: begin
                    if (byte_valid) begin
                        if (byte_data == r_sum) begin
                            r_state     <= ST_OUTPUT;
                            r_rd_ptr    <= '0;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_CHK;
`ifdef UART_FRAME_STATS_EN
                            r_bad_cnt   <= sat_inc16(r_bad_cnt);
`endif
                        end
                    end else if (w_tmo) begin
                        r_state     <= ST_IDLE;
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TMO;
`ifdef UART_FRAME_STATS_EN
                        r_bad_cnt   <= sat_inc16(r_bad_cnt);
`endif
                    end
                end

                ST_OUTPUT: begin
                    // Input is not buffered during replay; any byte is lost.
                    r_overrun <= byte_valid;
                    if (!r_out_valid) begin
                        // First cycle in OUTPUT loads the output register,
                        // giving the two-cycle CHK-to-out_valid latency.
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_rd_data;
                        r_out_last  <= w_next_last;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
`ifdef UART_FRAME_STATS_EN
                            r_good_cnt  <= sat_inc16(r_good_cnt);
`endif
                        end else begin
                            r_rd_ptr   <= r_rd_ptr + AW'(1);
                            r_out_data <= w_rd_data;
                            r_out_last <= w_next_last;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign overrun   = r_overrun;
`ifdef UART_FRAME_STATS_EN
    assign good_cnt  = r_good_cnt;
    assign bad_cnt   = r_bad_cnt;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
// Frame-level reference model compared against the parser every cycle, plus
// directed frames with literal expectations and a randomized frame mix.
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int         MAXL = 16;
    localparam int         TMO  = 64;
    localparam logic [7:0] HDR  = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    uart_frame_parser #(
        .HEADER         (HDR),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .overrun    (overrun)
`ifdef UART_FRAME_STATS_EN
        ,
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int         m_mode;      // 0 hunting for header, 1 collecting, 2 replaying
    logic [7:0] m_col[$];    // bytes after the header: LEN, payload, CHK
    int         m_gap;       // idle cycles since last accepted byte
    logic [7:0] m_out[$];    // payload being replayed
    int         m_idx;
    bit         m_ov;
    bit         e_ferr;
    bit         e_ovr;
    logic [1:0] e_code;
    int         m_good;
    int         m_bad;

    task automatic model_reset();
        m_mode = 0; m_col.delete(); m_gap = 0; m_out.delete(); m_idx = 0;
        m_ov = 0; e_ferr = 0; e_ovr = 0; e_code = 2'b00; m_good = 0; m_bad = 0;
    endtask

    task automatic model_err(input logic [1:0] c);
        e_ferr = 1; e_code = c; m_mode = 0;
        if (m_bad < 65535) m_bad++;
    endtask

    task automatic model_step(input bit bv, input logic [7:0] bd, input bit rdy);
        int L;
        int s;
        e_ferr = 0;
        e_ovr  = 0;
        case (m_mode)
            0: if (bv && bd == HDR) begin
                m_mode = 1; m_col.delete(); m_gap = 0;
            end
            1: begin
                if (bv) begin
                    m_col.push_back(bd);
                    m_gap = 0;
                    L = int'(m_col[0]);
                    if (m_col.size() == 1) begin
                        if (L == 0 || L > MAXL) model_err(2'b01);
                    end else if (m_col.size() == L + 2) begin
                        s = 0;
                        for (int i = 0; i <= L; i++) s += int'(m_col[i]);
                        if ((s % 256) == int'(m_col[L+1])) begin
                            m_out.delete();
                            for (int i = 1; i <= L; i++) m_out.push_back(m_col[i]);
                            m_idx = 0; m_ov = 0; m_mode = 2;
                        end else begin
                            model_err(2'b10);
                        end
                    end
                end else begin
                    m_gap++;
                    if (m_gap >= TMO) model_err(2'b11);
                end
            end
            default: begin
                if (bv) e_ovr = 1;
                if (!m_ov) begin
                    m_ov = 1;
                end else if (rdy) begin
                    m_idx++;
                    if (m_idx == m_out.size()) begin
                        m_ov = 0; m_mode = 0;
                        if (m_good < 65535) m_good++;
                    end
                end
            end
        endcase
    endtask

    // Observations for literal checks.
    logic [7:0] rx_q[$];
    bit         rx_l[$];
    int         ferr_seen = 0;
    int         ovr_seen  = 0;

    // Single compare process: step the model on each edge, check 1 time unit later.
    always @(posedge clk) begin
        bit bv;
        bit rdy;
        logic [7:0] bd;
        bv  = (byte_valid === 1'b1);
        bd  = byte_data;
        rdy = (out_ready === 1'b1);
        if (out_valid === 1'b1 && rdy) begin
            rx_q.push_back(out_data);
            rx_l.push_back(out_last);
        end
        if (rst_n !== 1'b1) model_reset();
        else model_step(bv, bd, rdy);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_out[m_idx]));
            chk("out_last", 32'(out_last), 32'(m_idx == m_out.size() - 1));
        end
        chk("frame_err", 32'(frame_err), 32'(e_ferr));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("err_code", 32'(err_code), 32'(e_code));
`ifdef UART_FRAME_STATS_EN
        chk("good_cnt", 32'(good_cnt), 32'(m_good));
        chk("bad_cnt", 32'(bad_cnt), 32'(m_bad));
`endif
        if (frame_err === 1'b1) ferr_seen++;
        if (overrun === 1'b1) ovr_seen++;
    end

    // ---------------- stimulus ----------------
    int rdy_mode; // 0 always ready, 1 random, 2 held low
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready <= 1'b1;
            1:       out_ready <= 1'($urandom_range(0, 1));
            default: out_ready <= 1'b0;
        endcase
    end

    logic [7:0] fq[$];

    // Called at a negedge; leaves the bench at a negedge.
    task automatic send_q(input int maxgap);
        foreach (fq[i]) begin
            byte_valid = 1'b1;
            byte_data  = fq[i];
            @(negedge clk);
            byte_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_clear();
        rx_q.delete();
        rx_l.delete();
    endtask

    initial begin
        int f0;
        int o0;
        int L;
        int s;
        int kind;
        logic [7:0] b;

        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; rdy_mode = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame, always ready.
        rx_clear(); f0 = ferr_seen;
        fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_q(0); idle(10);
        chk("good_rx_count", 32'(rx_q.size()), 32'd3);
        if (rx_q.size() == 3) begin
            chk("good_rx0", 32'(rx_q[0]), 32'h11);
            chk("good_rx1", 32'(rx_q[1]), 32'h22);
            chk("good_rx2", 32'(rx_q[2]), 32'h33);
            chk("good_last", 32'({rx_l[0], rx_l[1], rx_l[2]}), 32'b001);
        end
        chk("good_no_err", 32'(ferr_seen - f0), 32'd0);

        // Checksum error.
        rx_clear(); f0 = ferr_seen;
        fq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_q(0); idle(5);
        chk("chk_err_pulses", 32'(ferr_seen - f0), 32'd1);
        chk("chk_err_code", 32'(err_code), 32'd2);
        chk("chk_no_out", 32'(rx_q.size()), 32'd0);

        // Length errors: zero and above MAX_LEN.
        f0 = ferr_seen;
        fq = '{8'hA5, 8'h00, 8'hA5, 8'h11};
        send_q(0); idle(5);
        chk("len_err_pulses", 32'(ferr_seen - f0), 32'd2);
        chk("len_err_code", 32'(err_code), 32'd1);

        // Timeout, then recovery with a good frame.
        rx_clear(); f0 = ferr_seen;
        fq = '{8'hA5, 8'h02, 8'h10};
        send_q(0); idle(TMO + 5);
        chk("tmo_err_pulses", 32'(ferr_seen - f0), 32'd1);
        chk("tmo_err_code", 32'(err_code), 32'd3);
        fq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_q(0); idle(8);
        chk("tmo_recover_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            chk("tmo_recover_data", 32'(rx_q[0]), 32'h7E);
            chk("tmo_recover_last", 32'(rx_l[0]), 32'd1);
        end

        // Backpressure with a dropped byte.
        rx_clear(); o0 = ovr_seen; rdy_mode = 2;
        fq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
        send_q(0); idle(20);
        fq = '{8'h55};
        send_q(0); idle(29);
        chk("bp_overrun", 32'(ovr_seen - o0), 32'd1);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_data_held", 32'(out_data), 32'h01);
        rdy_mode = 0; idle(10);
        chk("bp_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("bp_rx0", 32'(rx_q[0]), 32'h01);
            chk("bp_rx1", 32'(rx_q[1]), 32'h02);
        end

        // Reset during payload.
        fq = '{8'hA5, 8'h03, 8'h01};
        send_q(0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
        chk("mid_rst_err_code", 32'(err_code), 32'd0);
        idle(2);
        rst_n = 1'b1;
        rx_clear(); f0 = ferr_seen;
        idle(1);
        fq = '{8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h17};
        send_q(0); idle(8);
        chk("post_rst_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("post_rst_rx0", 32'(rx_q[0]), 32'h0A);
            chk("post_rst_rx1", 32'(rx_q[1]), 32'h0B);
        end
        chk("post_rst_no_err", 32'(ferr_seen - f0), 32'd0);
`ifdef UART_FRAME_STATS_EN
        chk("post_rst_good_cnt", 32'(good_cnt), 32'd1);
`endif

        // Randomized frame mix; the compare process checks every cycle.
        for (int n = 0; n < 200; n++) begin
            rdy_mode = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            fq.delete();
            if (kind == 8) begin
                repeat ($urandom_range(1, 3)) fq.push_back(8'($urandom));
            end else if (kind == 6) begin
                fq.push_back(HDR);
                fq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
            end else begin
                L = $urandom_range(1, MAXL);
                fq.push_back(HDR);
                fq.push_back(8'(L));
                s = L;
                for (int i = 0; i < L; i++) begin
                    b = 8'($urandom);
                    if (kind == 9 && $urandom_range(0, 2) == 0) b = HDR;
                    fq.push_back(b);
                    s += int'(b);
                end
                if (kind == 5) fq.push_back(8'(s + $urandom_range(1, 255)));
                else if (kind == 7) begin
                    repeat ($urandom_range(0, L)) void'(fq.pop_back());
                end else fq.push_back(8'(s));
            end
            send_q(2);
            if (kind == 7) idle(TMO + 3);
            else idle($urandom_range(0, 12));
        end
        rdy_mode = 0;
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
